// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM/blink capture block.
// Optional glitch filter is selected with PWM_CAPTURE_GLITCH_FILTER_EN.
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_ON   = 2'd2,
    ST_OFF  = 2'd3
  } state_t;

  localparam int DEF_CNT_W = 16;

  // All-ones value for a counter of width w (w up to 63).
  function automatic logic [63:0] sat_val(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/pwm_capture_sync.sv
// Input conditioning for pwm_capture: synchronizer, optional agreement filter
// (PWM_CAPTURE_GLITCH_FILTER_EN) and edge detector on the active-high level.
module pwm_capture_sync
  import pwm_capture_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_n,
  output logic lvl_act,
  output logic rise,
  output logic fall
);

  // Parameter sanity hook; an illegal value leaves an empty marker block.
  if (SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_bad_params
  end

  // Chain stores the inverted pin so the reset value 0 means inactive.
  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ~pwm_n};
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int AGR_W = $clog2(FILT_LEN + 1);

  logic [AGR_W-1:0] agr_cnt;
  logic             filt_q;

  // Level flips only on the FILT_LEN-th consecutive disagreeing sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      agr_cnt <= '0;
      filt_q  <= 1'b0;
    end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
      agr_cnt <= '0;
    end else if (agr_cnt == AGR_W'(FILT_LEN - 1)) begin
      agr_cnt <= '0;
      filt_q  <= sync_q[SYNC_STAGES-1];
    end else begin
      agr_cnt <= agr_cnt + AGR_W'(1);
    end
  end

  assign lvl_act = filt_q;
`else
  assign lvl_act = sync_q[SYNC_STAGES-1];
`endif

  logic lvl_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_d <= 1'b0;
    end else begin
      lvl_d <= lvl_act;
    end
  end

  assign rise = lvl_act & ~lvl_d;
  assign fall = ~lvl_act & lvl_d;

endmodule

// File: rtl/pwm_capture.sv
// Period / active-time capture of a slow active-low PWM line with a
// valid/ready result port. Glitch filter option: PWM_CAPTURE_GLITCH_FILTER_EN.
//
// state   | meaning
// IDLE    | disabled, counters cleared
// ARM     | waiting for the first active edge
// ON      | signal active, counting period and on-time
// OFF     | signal inactive, counting period only
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_n,
  input  logic             enable,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] on_time,
  output logic             overflow,
  output logic             missed
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_val(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic lvl_act;
  logic rise;
  logic fall;

  pwm_capture_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .pwm_n  (pwm_n),
    .lvl_act(lvl_act),
    .rise   (rise),
    .fall   (fall)
  );

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] period_nxt;
  logic [CNT_W-1:0] on_cnt;
  logic [CNT_W-1:0] on_nxt;
  logic             pub;
  logic             pub_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      period_cnt <= '0;
      on_cnt     <= '0;
    end else begin
      state      <= state_nxt;
      period_cnt <= period_nxt;
      on_cnt     <= on_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    period_nxt = period_cnt;
    on_nxt     = on_cnt;
    pub        = 1'b0;
    pub_ovf    = 1'b0;
    case (state)
      ST_IDLE: begin
        period_nxt = '0;
        on_nxt     = '0;
        if (enable) state_nxt = ST_ARM;
      end
      ST_ARM: begin
        period_nxt = '0;
        on_nxt     = '0;
        if (rise) begin
          state_nxt  = ST_ON;
          period_nxt = CNT_ONE;
          on_nxt     = CNT_ONE;
        end
      end
      ST_ON: begin
        if (period_cnt == CNT_MAX) begin
          pub       = 1'b1;
          pub_ovf   = 1'b1;
          state_nxt = ST_ARM;
        end else begin
          period_nxt = period_cnt + CNT_ONE;
          // The cycle of the inactive edge is not counted as on-time.
          if (fall) state_nxt = ST_OFF;
          else      on_nxt    = on_cnt + CNT_ONE;
        end
      end
      ST_OFF: begin
        if (period_cnt == CNT_MAX) begin
          pub       = 1'b1;
          pub_ovf   = 1'b1;
          state_nxt = ST_ARM;
        end else if (rise) begin
          pub        = 1'b1;
          state_nxt  = ST_ON;
          period_nxt = CNT_ONE;
          on_nxt     = CNT_ONE;
        end else begin
          period_nxt = period_cnt + CNT_ONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (!enable) begin
      state_nxt = ST_IDLE;
      pub       = 1'b0;
      pub_ovf   = 1'b0;
    end
  end

  // Result registers only reload when the slot is free or being drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meas_valid <= 1'b0;
      period     <= '0;
      on_time    <= '0;
      overflow   <= 1'b0;
      missed     <= 1'b0;
    end else if (!enable) begin
      meas_valid <= 1'b0;
      missed     <= 1'b0;
    end else if (pub) begin
      if (!meas_valid || meas_ready) begin
        meas_valid <= 1'b1;
        period     <= period_cnt;
        on_time    <= on_cnt;
        overflow   <= pub_ovf;
      end else begin
        missed <= 1'b1;
      end
    end else if (meas_valid && meas_ready) begin
      meas_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: random waveforms against a
// segment-level model of expected period/on-time results.
module tb_pwm_capture;

  localparam int CNT_W = 16;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int MINW = 3;
`else
  localparam int MINW = 1;
`endif

  typedef struct {
    int per;
    int on;
    bit ovf;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             pwm_n;
  logic             enable;
  logic             meas_ready;
  logic             meas_valid;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] on_time;
  logic             overflow;
  logic             missed;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_acc   = 0;
  exp_t exp_q[$];

  pwm_capture #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(2),
    .FILT_LEN   (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwm_n     (pwm_n),
    .enable    (enable),
    .meas_ready(meas_ready),
    .meas_valid(meas_valid),
    .period    (period),
    .on_time   (on_time),
    .overflow  (overflow),
    .missed    (missed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive_seg(input int lo, input int hi);
    pwm_n = 1'b0;
    step(lo);
    pwm_n = 1'b1;
    step(hi);
  endtask

  task automatic push_exp(input int per, input int on, input bit ovf);
    exp_t e;
    e.per = per;
    e.on  = on;
    e.ovf = ovf;
    exp_q.push_back(e);
  endtask

  // Each active edge after the first closes the previous low+high segment.
  task automatic run_round(input int n, input bit push);
    int lo_p;
    int hi_p;
    int lo;
    int hi;
    lo_p = 0;
    hi_p = 0;
    for (int i = 0; i < n; i++) begin
      lo = $urandom_range(12, MINW);
      hi = $urandom_range(12, MINW);
      if (i > 0 && push) push_exp(lo_p + hi_p, lo_p, 1'b0);
      drive_seg(lo, hi);
      lo_p = lo;
      hi_p = hi;
    end
  endtask

  task automatic reenable();
    enable = 1'b0;
    step(2);
    enable = 1'b1;
    step(3);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && meas_valid && meas_ready) begin
      n_acc++;
      chk("result_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("period", period, e.per);
        chk("on_time", on_time, e.on);
        chk("overflow", overflow, e.ovf);
      end
    end
  end

  initial begin : stim
    int acc0;
    rst_n      = 1'b0;
    pwm_n      = 1'b1;
    enable     = 1'b0;
    meas_ready = 1'b1;
    step(3);
    chk("rst_valid", meas_valid, 0);
    chk("rst_period", period, 0);
    chk("rst_on_time", on_time, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_missed", missed, 0);
    rst_n = 1'b1;
    step(2);

    // Fixed 10-cycle period, 4 cycles active.
    enable = 1'b1;
    step(5);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) push_exp(10, 4, 1'b0);
      drive_seg(4, 6);
    end
    step(6);
    chk("fixed_drain", exp_q.size(), 0);

    // Random waveforms.
    for (int r = 0; r < 5; r++) begin
      reenable();
      run_round($urandom_range(8, 3), 1'b1);
      step(6);
      chk("round_drain", exp_q.size(), 0);
      chk("round_missed", missed, 0);
    end

    // Stuck-active input saturates once.
    reenable();
    acc0 = n_acc;
    push_exp(65535, 65535, 1'b1);
    pwm_n = 1'b0;
    for (int i = 0; i < 70000 && n_acc == acc0; i++) step();
    chk("sat_seen", n_acc - acc0, 1);
    step(200);
    chk("sat_single", n_acc - acc0, 1);
    pwm_n = 1'b1;
    step(5);

    // Back-pressure: second result dropped, first held.
    reenable();
    meas_ready = 1'b0;
    push_exp(20, 5, 1'b0);
    drive_seg(5, 15);
    drive_seg(7, 15);
    drive_seg(5, 15);
    chk("hold_valid", meas_valid, 1);
    chk("hold_period", period, 20);
    chk("hold_on_time", on_time, 5);
    chk("hold_missed", missed, 1);
    acc0 = n_acc;
    meas_ready = 1'b1;
    step();
    chk("valid_fall", meas_valid, 0);
    step(4);
    chk("single_accept", n_acc - acc0, 1);
    chk("missed_sticky", missed, 1);

    // Enable dropped while active.
    meas_ready = 1'b0;
    drive_seg(4, 6);
    drive_seg(4, 6);
    drive_seg(4, 6);
    pwm_n = 1'b0;
    step(6);
    chk("pre_drop_valid", meas_valid, 1);
    chk("pre_drop_missed", missed, 1);
    enable = 1'b0;
    step();
    chk("drop_valid", meas_valid, 0);
    chk("drop_missed", missed, 0);
    step(3);
    meas_ready = 1'b1;
    enable     = 1'b1;
    step(4);
    pwm_n = 1'b1;
    step(5);
    run_round($urandom_range(7, 3), 1'b1);
    step(6);
    chk("reen_drain", exp_q.size(), 0);
    chk("reen_missed", missed, 0);

    // Asynchronous reset in the inactive phase.
    meas_ready = 1'b0;
    drive_seg(4, 6);
    drive_seg(4, 3);
    chk("pre_rst_valid", meas_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", meas_valid, 0);
    chk("arst_period", period, 0);
    chk("arst_on_time", on_time, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_missed", missed, 0);
    step(2);
    rst_n      = 1'b1;
    meas_ready = 1'b1;
    step(4);
    run_round($urandom_range(7, 3), 1'b1);
    step(6);
    chk("post_rst_drain", exp_q.size(), 0);

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    // Short inactive glitch inside the active phase must be absorbed.
    reenable();
    acc0 = n_acc;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) push_exp(16, 6, 1'b0);
      pwm_n = 1'b0;
      step(3);
      pwm_n = 1'b1;
      step(2);
      pwm_n = 1'b0;
      step(1);
      pwm_n = 1'b1;
      step(10);
    end
    step(6);
    chk("filt_count", n_acc - acc0, 2);
    chk("filt_drain", exp_q.size(), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
